// File: rtl/fetch_pkg.sv
// Shared widths, constants and the fetch-buffer entry type for the fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } fetch_entry_t;

  // Sequential PC increment; wraps naturally at 2^32.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order fetch buffer: synchronous write, registered storage, flush clears it.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  fetch_entry_t             wr_data,
  input  logic                     rd_en,
  output logic                     valid,
  output fetch_entry_t             head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          full;
  logic          do_rd;
  logic          do_wr;

  assign full      = (count == CW'(DEPTH));
  assign do_rd     = rd_en && valid;
  assign do_wr     = wr_en && (!full || do_rd);
  // Head entry comes straight out of storage registers, never from the write port.
  assign head_data = mem[head];

  // Storage, pointers, occupancy and a registered non-empty flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[PW'(i)] <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0};
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= 1'b0;
    end else begin
      if (do_wr) begin
        mem[tail] <= wr_data;
        tail      <= PW'(tail + 1'b1);
      end
      if (do_rd) begin
        head <= PW'(head + 1'b1);
      end
      case ({do_wr, do_rd})
        2'b10: begin
          count <= CW'(count + 1'b1);
          valid <= 1'b1;
        end
        2'b01: begin
          count <= CW'(count - 1'b1);
          valid <= (count != CW'(1));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection and a small decoupling buffer to decode.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Redirect_Valid,
  input  logic [XLEN-1:0] Redirect_Target,
  output logic [XLEN-1:0] IMem_Address,
  input  logic [XLEN-1:0] IMem_Instruction,
  output logic            Out_Valid,
  input  logic            Out_Ready,
  output logic [XLEN-1:0] Out_Instruction,
  output logic [XLEN-1:0] Out_PC,
  output logic [XLEN-1:0] Out_PCPlus4
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  if (DEPTH != 2 && DEPTH != 4) begin : g_bad_depth
    $error("fetch_stage: DEPTH must be 2 or 4");
  end

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [CW-1:0]   count;
  logic            deq;
  logic            fetch;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head_entry;

  // A slot frees up in the same cycle decode takes the head, so fetch can run back-to-back.
  assign deq          = Out_Valid && Out_Ready;
  assign fetch        = !Redirect_Valid && ((count < CW'(DEPTH)) || deq);
  assign IMem_Address = pc;

  // Entry captured from the combinational instruction memory at the current PC.
  always_comb begin
    wr_entry          = '0;
    wr_entry.instr    = IMem_Instruction;
    wr_entry.pc       = pc;
    wr_entry.pc_plus4 = pc_inc(pc);
  end

  // Next PC: redirect wins, otherwise advance only when an instruction is taken in.
  always_comb begin
    pc_next = pc;
    if (Redirect_Valid) begin
      pc_next = Redirect_Target & ~XLEN'(3);
    end else if (fetch) begin
      pc_next = pc_inc(pc);
    end
  end

  // PC register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (Clk),
    .rst      (Rst),
    .flush    (Redirect_Valid),
    .wr_en    (fetch),
    .wr_data  (wr_entry),
    .rd_en    (Out_Ready),
    .valid    (Out_Valid),
    .head_data(head_entry),
    .count    (count)
  );

  assign Out_Instruction = head_entry.instr;
  assign Out_PC          = head_entry.pc;
  assign Out_PCPlus4     = head_entry.pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async-reset sequence, then random run vs a queue model.
module tb_fetch_stage;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Redirect_Valid;
  logic [31:0] Redirect_Target;
  logic [31:0] IMem_Address;
  logic [31:0] IMem_Instruction;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [31:0] Out_Instruction;
  logic [31:0] Out_PC;
  logic [31:0] Out_PCPlus4;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] tgt;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;

  fetch_stage #(
    .RESET_PC(RPC),
    .DEPTH   (DEPTH)
  ) dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .Redirect_Valid  (Redirect_Valid),
    .Redirect_Target (Redirect_Target),
    .IMem_Address    (IMem_Address),
    .IMem_Instruction(IMem_Instruction),
    .Out_Valid       (Out_Valid),
    .Out_Ready       (Out_Ready),
    .Out_Instruction (Out_Instruction),
    .Out_PC          (Out_PC),
    .Out_PCPlus4     (Out_PCPlus4)
  );

  always #5 Clk = ~Clk;

  // Memory image: word[i] = 0x1000_0000 + i, indexed by address[15:2].
  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'h1000_0000 + {18'b0, a[15:2]};
  endfunction

  assign IMem_Instruction = memf(IMem_Address);

  function automatic vec_t mkv(input logic rdy, input logic redir, input logic [31:0] tgt,
                               input logic ev, input logic [31:0] epc, input logic [31:0] eaddr);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.tgt = tgt; v.ev = ev; v.epc = epc; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    vec_t        tbl [19];
    logic [31:0] q [$];
    logic [31:0] mpc;
    logic [31:0] exp_next;
    logic        rdy;
    logic        redir;
    logic [31:0] tgt;
    logic        deq;
    logic        fetch;
    int          hs;

    tbl[0]  = mkv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0);
    tbl[1]  = mkv(1'b1, 1'b0, 32'h0, 1'b1, 32'h0,         32'h4);
    tbl[2]  = mkv(1'b1, 1'b0, 32'h0, 1'b1, 32'h4,         32'h8);
    tbl[3]  = mkv(1'b0, 1'b0, 32'h0, 1'b1, 32'h8,         32'hC);
    tbl[4]  = mkv(1'b0, 1'b0, 32'h0, 1'b1, 32'h8,         32'h10);
    tbl[5]  = mkv(1'b0, 1'b0, 32'h0, 1'b1, 32'h8,         32'h10);
    tbl[6]  = mkv(1'b0, 1'b0, 32'h0, 1'b1, 32'h8,         32'h10);
    tbl[7]  = mkv(1'b0, 1'b0, 32'h0, 1'b1, 32'h8,         32'h10);
    tbl[8]  = mkv(1'b1, 1'b0, 32'h0, 1'b1, 32'h8,         32'h10);
    tbl[9]  = mkv(1'b1, 1'b0, 32'h0, 1'b1, 32'hC,         32'h14);
    tbl[10] = mkv(1'b1, 1'b0, 32'h0, 1'b1, 32'h10,        32'h18);
    tbl[11] = mkv(1'b0, 1'b0, 32'h0, 1'b1, 32'h14,        32'h1C);
    tbl[12] = mkv(1'b0, 1'b1, 32'h0000_0103, 1'b1, 32'h14, 32'h1C);
    tbl[13] = mkv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         32'h100);
    tbl[14] = mkv(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'h100, 32'h104);
    tbl[15] = mkv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         32'hFFFF_FFF8);
    tbl[16] = mkv(1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
    tbl[17] = mkv(1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h0);
    tbl[18] = mkv(1'b0, 1'b0, 32'h0, 1'b1, 32'h0,         32'h4);

    Rst = 1'b1;
    Redirect_Valid = 1'b0;
    Redirect_Target = 32'h0;
    Out_Ready = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_valid", {31'b0, Out_Valid}, 32'h0);
    chk("rst_instr", Out_Instruction, 32'h0);
    chk("rst_pc", Out_PC, 32'h0);
    chk("rst_pc4", Out_PCPlus4, 32'h0);
    chk("rst_addr", IMem_Address, RPC);
    Rst = 1'b0;

    // Directed vectors: startup, stall at full, redirect, wrap at the top of memory.
    for (int i = 0; i < 19; i++) begin
      chk($sformatf("vec%0d_valid", i), {31'b0, Out_Valid}, {31'b0, tbl[i].ev});
      chk($sformatf("vec%0d_addr", i), IMem_Address, tbl[i].eaddr);
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_pc", i), Out_PC, tbl[i].epc);
        chk($sformatf("vec%0d_instr", i), Out_Instruction, memf(tbl[i].epc));
        chk($sformatf("vec%0d_pc4", i), Out_PCPlus4, tbl[i].epc + 32'd4);
      end
      Out_Ready       = tbl[i].rdy;
      Redirect_Valid  = tbl[i].redir;
      Redirect_Target = tbl[i].tgt;
      @(posedge Clk);
      #1;
    end
    Redirect_Valid = 1'b0;
    Out_Ready = 1'b0;

    // Two entries buffered (0x0, 0x4), PC at 0x8; pulse reset mid-cycle.
    chk("pre_rst_pc", Out_PC, 32'h0);
    chk("pre_rst_addr", IMem_Address, 32'h8);
    #3;
    Rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, Out_Valid}, 32'h0);
    chk("async_rst_addr", IMem_Address, RPC);
    chk("async_rst_pc", Out_PC, 32'h0);
    #2;
    Rst = 1'b0;
    #1;
    chk("post_rst_addr", IMem_Address, RPC);
    chk("post_rst_valid", {31'b0, Out_Valid}, 32'h0);

    // Random run against a queue-of-addresses model; second half toggles ready with a scoreboard.
    q.delete();
    mpc = RPC;
    exp_next = 32'h0;
    hs = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("m_valid", {31'b0, Out_Valid}, {31'b0, q.size() != 0});
      chk("m_addr", IMem_Address, mpc);
      if (q.size() != 0) begin
        chk("m_pc", Out_PC, q[0]);
        chk("m_instr", Out_Instruction, memf(q[0]));
        chk("m_pc4", Out_PCPlus4, q[0] + 32'd4);
      end
      if (c == 1500) begin
        exp_next = (q.size() != 0) ? q[0] : mpc;
      end

      if (c < 1500) begin
        rdy   = ((c / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
        redir = ($urandom_range(0, 15) == 0);
        tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                            : $urandom();
      end else begin
        rdy   = c[0];
        redir = 1'b0;
        tgt   = 32'h0;
      end
      Out_Ready       = rdy;
      Redirect_Valid  = redir;
      Redirect_Target = tgt;

      if (c >= 1500 && Out_Valid && Out_Ready) begin
        chk("sb_order", Out_PC, exp_next);
        exp_next = exp_next + 32'd4;
        hs++;
      end

      deq = (q.size() != 0) && rdy;
      if (redir) begin
        q.delete();
        mpc = tgt & ~32'd3;
      end else begin
        fetch = (q.size() < int'(DEPTH)) || deq;
        if (deq) begin
          void'(q.pop_front());
        end
        if (fetch) begin
          q.push_back(mpc);
          mpc = mpc + 32'd4;
        end
      end

      @(posedge Clk);
      #1;
    end
    chk("sb_progress", {31'b0, hs >= 700}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset (bits [1:0] SHALL be 0).
REQ-002 Parameter DEPTH, default 2, is the fetch-buffer entry count; legal values are 2 and 4.
REQ-003 Clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Rst  input  1  is the reset: asynchronous, active-high.
REQ-005 Redirect_Valid  input  1  is the branch/jump redirect request from a later stage.
REQ-006 Redirect_Target  input  32  is the redirect destination byte address.
REQ-007 IMem_Address  output  32  is the byte address presented to the combinational instruction memory (word index = address[15:2]).
REQ-008 IMem_Instruction  input  32  is the instruction word returned combinationally for IMem_Address.
REQ-009 Out_Valid  output  1  means the buffer head holds a valid fetched instruction.
REQ-010 Out_Ready  input  1  is decode's acceptance of the head entry.
REQ-011 Out_Instruction, Out_PC, Out_PCPlus4  output  32 each  are the head entry's instruction, its address, and its address+4.

Function
REQ-012 The block SHALL hold a 32-bit PC register and drive IMem_Address = PC combinationally.
REQ-013 Dequeue SHALL occur in a cycle iff Out_Valid && Out_Ready.
REQ-014 Fetch (enqueue) SHALL occur in a cycle iff Redirect_Valid=0 and (count<DEPTH or a dequeue occurs in the same cycle).
REQ-015 On fetch, the entry {IMem_Instruction, PC, PC+4} SHALL be written at the tail and PC SHALL become PC+4.
REQ-016 When no fetch occurs and Redirect_Valid=0, PC SHALL hold.
REQ-017 PC+4 SHALL be computed modulo 2^32 (0xFFFF_FFFC increments to 0x0000_0000).
REQ-018 Redirect_Valid=1 SHALL take priority: all buffer entries are discarded (count becomes 0), no enqueue occurs, and PC becomes {Redirect_Target[31:2],2'b00}.
REQ-019 A dequeue in the same cycle as a redirect SHALL still count as a handshake, but the buffer SHALL be empty on the next cycle.
REQ-020 Simultaneous enqueue and dequeue SHALL leave count unchanged and preserve order.
REQ-021 Out_Valid SHALL equal (count != 0); the Out_* data SHALL be the head entry, registered, with no combinational path from IMem_Instruction.
REQ-022 With Out_Ready=1 continuously, the instruction at address A SHALL appear on Out_* exactly one cycle after PC=A, sustaining one instruction per cycle.
REQ-023 While Out_Valid=1 and Out_Ready=0, Out_* SHALL remain stable.
REQ-024 The buffer SHALL never overflow or underflow; count ranges 0..DEPTH.

Reset
REQ-025 While Rst=1: PC=RESET_PC, count=0, head/tail pointers=0, Out_Valid=0, and Out_Instruction/Out_PC/Out_PCPlus4 = 0.
REQ-026 IMem_Address SHALL equal RESET_PC during reset and in the first cycle after it.
REQ-027 Rst asserted mid-operation SHALL discard all buffered entries immediately, without waiting for a clock edge.
REQ-028 Fetching SHALL begin on the first rising edge after Rst deasserts.

Structure
REQ-029 The shared package SHALL hold RESET_PC_DEFAULT, the instruction/address width (32), and NOP_INSTR (32'h0000_0000).
REQ-030 The buffer SHALL be a sub-module fetch_fifo (synchronous write, registered head, flush input, async reset) instantiated once.
REQ-031 The PC register, next-PC mux, and fetch-enable logic SHALL reside in fetch_stage itself.

Verification
REQ-032 Reset release with Out_Ready=1 and memory word[i]=0x1000_0000+i -> Out_PC 0x0, 0x4, 0x8 on consecutive cycles, with matching instructions and Out_Valid=1 from cycle 2.
REQ-033 Out_Ready=0 for 5 cycles from PC=0x8 -> count saturates at DEPTH, PC freezes at 0x8+4*DEPTH, and Out_* holds 0x8; releasing Out_Ready resumes the sequence in order with no loss or duplication.
REQ-034 Redirect_Valid=1 with Redirect_Target=0x0000_0103 while the buffer is full -> next cycle Out_Valid=0, PC=0x100; the following cycle Out_PC=0x100.
REQ-035 PC forced near the top via redirect to 0xFFFF_FFF8 with Out_Ready=1 -> Out_PC sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, and Out_PCPlus4 of the 0xFFFF_FFFC entry is 0.
REQ-036 Rst pulsed asynchronously mid-cycle with 2 entries buffered -> Out_Valid drops to 0 and PC becomes RESET_PC before the next edge; fetch restarts at RESET_PC.
REQ-037 Out_Ready toggled every cycle -> every address appears exactly once, in order; a scoreboard confirms no drop or duplicate.
